// File: rtl/vend_pkg.sv
// Shared state encoding and display constants for the multi-item vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } vend_state_t;

    // Active-low {a,b,c,d,e,f,g} patterns for hex digits 0..F.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    localparam logic [6:0] SEG_RESET = 7'b0000001;
    localparam logic [7:0] AN_CREDIT = 8'b1111_1110;
    localparam logic [7:0] AN_CHANGE = 8'b1111_0111;

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational 4-bit value to active-low 7-segment pattern; the parent registers it.
module seg7_hex_decoder
    import vend_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[value];

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-item vending controller: coin credit, per-item price/stock, change, cancel,
// inactivity refund and a single 7-segment digit showing credit or last change.
module vending_machine_multi
    import vend_pkg::*;
#(
    parameter int                            NUM_ITEMS   = 4,
    parameter int                            SEL_W       = 2,
    parameter int                            CREDIT_W    = 4,
    parameter int                            MAX_CREDIT  = 15,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES      = {4'd7, 4'd5, 4'd3, 4'd2},
    parameter int                            STOCK_W     = 3,
    parameter int                            STOCK_INIT  = 3,
    parameter int                            TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [CREDIT_W-1:0] coin_val,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel_item,
    input  logic                cancel,
    input  logic                restock,
    input  logic                disp_sel,
    output logic                coin_reject,
    output logic                sel_error,
    output logic                dispense,
    output logic [SEL_W-1:0]    dispense_item,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_val,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic [6:0]          d,
    output logic [7:0]          an
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CREDIT_W:0] MAX_SUM = (CREDIT_W + 1)'(MAX_CREDIT);

    vend_state_t state, state_next;

    logic [STOCK_W-1:0]  stock [NUM_ITEMS];
    logic [TO_W-1:0]     idle_cnt;
    logic                refund_pending;

    logic                in_purchase;
    logic                activity;
    logic                timeout_fire;
    logic                do_cancel;
    logic                do_sel;
    logic                sel_ok;
    logic                sel_hit;
    logic                sel_stock_empty;
    logic [CREDIT_W-1:0] sel_price;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_ok;
    logic                coin_accept;
    logic                coin_rej;

    logic [CREDIT_W-1:0] credit_nx;
    logic [CREDIT_W-1:0] change_val_nx;
    logic [SEL_W-1:0]    dispense_item_nx;
    logic                dispense_nx;
    logic                change_valid_nx;
    logic                refund_nx;

    logic [3:0]          disp_value;
    logic [6:0]          seg_nx;

    // Price and stock lookup for the requested item; an index with no item leaves sel_hit low.
    always_comb begin
        sel_hit         = 1'b0;
        sel_price       = '0;
        sel_stock_empty = 1'b1;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (sel_item == SEL_W'(i)) begin
                sel_hit         = 1'b1;
                sel_price       = PRICES[i*CREDIT_W +: CREDIT_W];
                sel_stock_empty = (stock[i] == '0);
            end
        end
    end

    // Per-cycle request decode with priority cancel > select > coin.
    assign in_purchase  = (state == IDLE) || (state == CREDIT);
    assign activity     = coin_valid || sel_valid || cancel;
    assign timeout_fire = (state == CREDIT) && !activity
                          && (idle_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign do_cancel    = (state == CREDIT) && (cancel || timeout_fire);
    assign do_sel       = in_purchase && sel_valid && !cancel;
    assign sel_ok       = do_sel && sel_hit && !sel_stock_empty && (credit >= sel_price);
    assign coin_sum     = {1'b0, credit} + {1'b0, coin_val};
    assign coin_ok      = (coin_val != '0) && (coin_sum <= MAX_SUM);
    assign coin_accept  = in_purchase && coin_valid && !cancel && !sel_valid && coin_ok;
    assign coin_rej     = coin_valid && !coin_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, CREDIT: begin
                if (do_cancel) begin
                    state_next = CHANGE;
                end else if (sel_ok) begin
                    state_next = VEND;
                end else if (coin_accept) begin
                    state_next = CREDIT;
                end
            end
            VEND:    state_next = CHANGE;
            CHANGE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Refunds announce change one cycle after entering CHANGE, purchases as they enter it,
    // so both paths pulse change_valid two cycles after the request.
    always_comb begin
        credit_nx        = credit;
        change_val_nx    = change_val;
        dispense_item_nx = dispense_item;
        dispense_nx      = 1'b0;
        change_valid_nx  = 1'b0;
        refund_nx        = 1'b0;
        if (do_cancel) begin
            change_val_nx = credit;
            credit_nx     = '0;
            refund_nx     = 1'b1;
        end else if (sel_ok) begin
            dispense_nx      = 1'b1;
            dispense_item_nx = sel_item;
            change_val_nx    = credit - sel_price;
            credit_nx        = '0;
        end else if (coin_accept) begin
            credit_nx = coin_sum[CREDIT_W-1:0];
        end
        if (((state == VEND) || ((state == CHANGE) && refund_pending)) && (change_val != '0)) begin
            change_valid_nx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit         <= '0;
            change_val     <= '0;
            dispense       <= 1'b0;
            dispense_item  <= '0;
            change_valid   <= 1'b0;
            coin_reject    <= 1'b0;
            sel_error      <= 1'b0;
            busy           <= 1'b0;
            refund_pending <= 1'b0;
            idle_cnt       <= '0;
        end else begin
            credit         <= credit_nx;
            change_val     <= change_val_nx;
            dispense       <= dispense_nx;
            dispense_item  <= dispense_item_nx;
            change_valid   <= change_valid_nx;
            coin_reject    <= coin_rej;
            sel_error      <= do_sel && !sel_ok;
            busy           <= (state_next == VEND) || (state_next == CHANGE);
            refund_pending <= refund_nx;
            if ((state == CREDIT) && !activity && !timeout_fire) begin
                idle_cnt <= idle_cnt + TO_W'(1);
            end else begin
                idle_cnt <= '0;
            end
        end
    end

    // Restock wins over a coincident purchase decrement; counters never go below zero.
    for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_stock
        logic [STOCK_W-1:0] count;

        always_ff @(posedge clk) begin
            if (rst || restock) begin
                count <= STOCK_W'(STOCK_INIT);
            end else if (sel_ok && (sel_item == SEL_W'(i)) && (count != '0)) begin
                count <= count - STOCK_W'(1);
            end
        end

        assign stock[i] = count;
    end

    assign disp_value = disp_sel ? change_val[3:0] : credit[3:0];

    seg7_hex_decoder u_seg7 (
        .value (disp_value),
        .seg   (seg_nx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            d  <= SEG_RESET;
            an <= AN_CREDIT;
        end else begin
            d  <= seg_nx;
            an <= disp_sel ? AN_CHANGE : AN_CREDIT;
        end
    end

endmodule

// File: tb/tb_vending_machine_multi.sv
// Scoreboard bench for vending_machine_multi: expected pulses are queued with the cycle
// they must appear in and matched by a monitor just after each rising edge.
module tb_vending_machine_multi;

    localparam int EV_DISP = 1;
    localparam int EV_CHG  = 2;
    localparam int EV_REJ  = 3;
    localparam int EV_SERR = 4;

    typedef struct {
        int kind;
        int val;
        int at;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_valid;
    logic [3:0] coin_val;
    logic       sel_valid;
    logic [1:0] sel_item;
    logic       cancel;
    logic       restock;
    logic       disp_sel;
    logic       coin_reject;
    logic       sel_error;
    logic       dispense;
    logic [1:0] dispense_item;
    logic       change_valid;
    logic [3:0] change_val;
    logic [3:0] credit;
    logic       busy;
    logic [6:0] d;
    logic [7:0] an;

    int   cyc = 0;
    int   tests = 0;
    int   failures = 0;
    int   k;
    ev_t  expq [$];

    vending_machine_multi dut (
        .clk           (clk),
        .rst           (rst),
        .coin_valid    (coin_valid),
        .coin_val      (coin_val),
        .sel_valid     (sel_valid),
        .sel_item      (sel_item),
        .cancel        (cancel),
        .restock       (restock),
        .disp_sel      (disp_sel),
        .coin_reject   (coin_reject),
        .sel_error     (sel_error),
        .dispense      (dispense),
        .dispense_item (dispense_item),
        .change_valid  (change_valid),
        .change_val    (change_val),
        .credit        (credit),
        .busy          (busy),
        .d             (d),
        .an            (an)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] evCode(input int kind, input int val, input int at);
        return (32'(at) << 12) | (32'(kind) << 8) | 32'(val);
    endfunction

    task automatic expectEvent(input int kind, input int val, input int at);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.at   = at;
        expq.push_back(e);
    endtask

    task automatic observe(input int kind, input int val);
        ev_t e;
        if (expq.size() == 0) begin
            checkOutput("sb_unexpected", evCode(kind, val, cyc), 32'd0);
        end else begin
            e = expq.pop_front();
            checkOutput("sb_event", evCode(kind, val, cyc), evCode(e.kind, e.val, e.at));
        end
    endtask

    // Pulses are collected in a fixed order so same-cycle expectations queue the same way.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (dispense)     observe(EV_DISP, int'(dispense_item));
            if (change_valid) observe(EV_CHG, int'(change_val));
            if (coin_reject)  observe(EV_REJ, 0);
            if (sel_error)    observe(EV_SERR, 0);
        end
    end

    // Drives one cycle of inputs starting at a falling edge and returns at the next one.
    task automatic applyStimulus(input logic cv, input logic [3:0] cval, input logic sv,
                                 input logic [1:0] item, input logic canc, input logic rstk);
        coin_valid = cv;
        coin_val   = cval;
        sel_valid  = sv;
        sel_item   = item;
        cancel     = canc;
        restock    = rstk;
        @(negedge clk);
        coin_valid = 1'b0;
        coin_val   = 4'd0;
        sel_valid  = 1'b0;
        sel_item   = 2'd0;
        cancel     = 1'b0;
        restock    = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        coin_valid = 1'b0;
        coin_val   = 4'd0;
        sel_valid  = 1'b0;
        sel_item   = 2'd0;
        cancel     = 1'b0;
        restock    = 1'b0;
        disp_sel   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        checkOutput("rst_credit", credit, 0);
        checkOutput("rst_change_val", change_val, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_dispense_item", dispense_item, 0);
        checkOutput("rst_seg", d, 7'b0000001);
        checkOutput("rst_an", an, 8'b11111110);

        // Coins 2+2, buy item 1 (price 3), change 1.
        applyStimulus(1'b1, 4'd2, 1'b0, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd2, 1'b0, 2'd0, 1'b0, 1'b0);
        checkOutput("t1_credit", credit, 4);
        idleCycles(1);
        checkOutput("t1_seg_credit", d, 7'b1001100);
        k = cyc + 1;
        expectEvent(EV_DISP, 1, k);
        expectEvent(EV_CHG, 1, k + 1);
        applyStimulus(1'b0, 4'd0, 1'b1, 2'd1, 1'b0, 1'b0);
        checkOutput("t1_busy_vend", busy, 1);
        idleCycles(3);
        checkOutput("t1_change_val", change_val, 1);
        checkOutput("t1_credit_after", credit, 0);
        disp_sel = 1'b1;
        idleCycles(1);
        checkOutput("t1_an_change", an, 8'b11110111);
        checkOutput("t1_seg_change", d, 7'b1001111);
        disp_sel = 1'b0;

        // Fill to the ceiling, overflow coin refused, then cancel refunds everything.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'd5, 1'b0, 2'd0, 1'b0, 1'b0);
        checkOutput("t2_credit_full", credit, 15);
        k = cyc + 1;
        expectEvent(EV_REJ, 0, k);
        applyStimulus(1'b1, 4'd2, 1'b0, 2'd0, 1'b0, 1'b0);
        checkOutput("t2_credit_kept", credit, 15);
        idleCycles(1);
        checkOutput("t2_seg_f", d, 7'b0111000);
        k = cyc + 1;
        expectEvent(EV_CHG, 15, k + 1);
        applyStimulus(1'b0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b0);
        checkOutput("t2_busy_cancel", busy, 1);
        checkOutput("t2_credit_cleared", credit, 0);
        idleCycles(2);
        checkOutput("t2_busy_done", busy, 0);
        checkOutput("t2_change_val", change_val, 15);

        // Item 0 sells out after three exact-credit buys; restock makes it available again.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'd2, 1'b0, 2'd0, 1'b0, 1'b0);
            k = cyc + 1;
            if (i < 3) expectEvent(EV_DISP, 0, k);
            else       expectEvent(EV_SERR, 0, k);
            applyStimulus(1'b0, 4'd0, 1'b1, 2'd0, 1'b0, 1'b0);
            idleCycles(2);
        end
        checkOutput("t3_credit_soldout", credit, 2);
        checkOutput("t3_change_exact", change_val, 0);
        applyStimulus(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        k = cyc + 1;
        expectEvent(EV_DISP, 0, k);
        applyStimulus(1'b0, 4'd0, 1'b1, 2'd0, 1'b0, 1'b0);
        idleCycles(2);
        checkOutput("t3_credit_restock", credit, 0);

        // Insufficient credit for item 3, then the inactivity timeout refunds the 2.
        applyStimulus(1'b1, 4'd2, 1'b0, 2'd0, 1'b0, 1'b0);
        k = cyc + 1;
        expectEvent(EV_SERR, 0, k);
        expectEvent(EV_CHG, 2, k + 1001);
        applyStimulus(1'b0, 4'd0, 1'b1, 2'd3, 1'b0, 1'b0);
        checkOutput("t4_credit_kept", credit, 2);
        idleCycles(1010);
        checkOutput("t4_credit_timeout", credit, 0);
        checkOutput("t4_change_val", change_val, 2);
        checkOutput("t4_busy", busy, 0);

        // Coin loses to a same-cycle select; another coin arrives during VEND.
        applyStimulus(1'b1, 4'd5, 1'b0, 2'd0, 1'b0, 1'b0);
        k = cyc + 1;
        expectEvent(EV_DISP, 1, k);
        expectEvent(EV_REJ, 0, k);
        expectEvent(EV_CHG, 2, k + 1);
        expectEvent(EV_REJ, 0, k + 1);
        applyStimulus(1'b1, 4'd2, 1'b1, 2'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd1, 1'b0, 2'd0, 1'b0, 1'b0);
        idleCycles(2);
        checkOutput("t5_credit", credit, 0);
        checkOutput("t5_change_val", change_val, 2);

        // Reset during VEND drops the pending change.
        applyStimulus(1'b1, 4'd5, 1'b0, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd2, 1'b0, 2'd0, 1'b0, 1'b0);
        checkOutput("t6_credit", credit, 7);
        k = cyc + 1;
        expectEvent(EV_DISP, 1, k);
        applyStimulus(1'b0, 4'd0, 1'b1, 2'd1, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_credit", credit, 0);
        checkOutput("t6_change_val", change_val, 0);
        checkOutput("t6_seg", d, 7'b0000001);
        checkOutput("t6_dispense_item", dispense_item, 0);
        idleCycles(4);

        checkOutput("sb_drain", 32'(expq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
